pacman_motion_ctrl: RTL and testbench

- Movement stage for one character (pacman or one ghost). Holds the character's display position and drives it into the valid-move detector.
- Consumes the detector's one-hot valid_moves and a requested direction (joystick, or ghost AI).
- Advances the position by STEP_PX pixels per move_tick, with turn, stop, reversal and tunnel wrap-around rules.
- One instance per character, ahead of the sprite renderer and the collision logic.

---
 rtl/pacman_pkg.sv | 46 ++++
 rtl/pacman_dir_arbiter.sv | 56 +++++
 rtl/pacman_motion_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pacman_motion_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// -----------------------------------------------------------------------------
// pacman_pkg
// Shared definitions for the character motion stage:
//   - one-hot direction encodings {Left, Down, Up, Right}, DIR_NONE = stopped
//   - dir_opposite(): reverse heading lookup
//   - dir_is_onehot(): legality test for a requested direction
//   - default map geometry (TILE_PX_DEF, MAP_COLS_DEF)
//   - motion FSM state encoding
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package pacman_pkg;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_NONE  = 4'b0000;
    localparam dir_t DIR_RIGHT = 4'b0001;
    localparam dir_t DIR_UP    = 4'b0010;
    localparam dir_t DIR_DOWN  = 4'b0100;
    localparam dir_t DIR_LEFT  = 4'b1000;

    localparam int TILE_PX_DEF  = 16;
    localparam int MAP_COLS_DEF = 80;

    // Motion FSM states
    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_READY  = 2'd1;
    localparam logic [1:0] ST_MOVE   = 2'd2;

    function automatic dir_t dir_opposite(input dir_t d);
        dir_t r;
        case (d)
            DIR_RIGHT: r = DIR_LEFT;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            default:   r = DIR_NONE;
        endcase
        return r;
    endfunction

    function automatic logic dir_is_onehot(input dir_t d);
        return (d != DIR_NONE) && ((d & (d - 4'd1)) == DIR_NONE);
    endfunction

endpackage

// File: rtl/pacman_dir_arbiter.sv
// -----------------------------------------------------------------------------
// pacman_dir_arbiter
// Combinational heading decision, evaluated by the motion controller in its
// MOVE cycle. First matching rule wins:
//   reversal (any position) > requested turn (aligned) > keep heading
//   (aligned) > stop (aligned) > keep heading (mid-tile, walls ignored).
// Ports:
//   cur_dir_i     current heading (one-hot, 0 = stopped)
//   req_dir_i     live request, used only for the reversal rule
//   turn_req_i    request considered for a turn at a tile centre
//   valid_moves_i legal directions from the detector
//   aligned_i     position is on a tile boundary in both axes
//   next_dir_o    heading after this move
//   stop_o        character stops against a wall (pos must not change)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pacman_dir_arbiter
    import pacman_pkg::*;
(
    input  logic [3:0] cur_dir_i,
    input  logic [3:0] req_dir_i,
    input  logic [3:0] turn_req_i,
    input  logic [3:0] valid_moves_i,
    input  logic       aligned_i,
    output logic [3:0] next_dir_o,
    output logic       stop_o
);

    logic req_onehot;
    logic turn_onehot;
    logic reverse;

    assign req_onehot  = dir_is_onehot(req_dir_i);
    assign turn_onehot = dir_is_onehot(turn_req_i);
    // dir_opposite(DIR_NONE) is DIR_NONE, so a stopped character never "reverses".
    assign reverse     = req_onehot && (req_dir_i == dir_opposite(cur_dir_i));

    always_comb begin
        next_dir_o = cur_dir_i;
        stop_o     = 1'b0;
        if (reverse) begin
            next_dir_o = req_dir_i;
        end else if (aligned_i) begin
            if (turn_onehot && ((turn_req_i & valid_moves_i) != DIR_NONE)) begin
                next_dir_o = turn_req_i;
            end else if ((cur_dir_i & valid_moves_i) != DIR_NONE) begin
                next_dir_o = cur_dir_i;
            end else begin
                next_dir_o = DIR_NONE;
                stop_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// -----------------------------------------------------------------------------
// pacman_motion_ctrl
// Movement stage for one character. Holds the display position, feeds it to
// the valid-move detector, waits for the detector to settle, then advances
// by STEP_PX on each move_tick using the rules in pacman_dir_arbiter.
// X wraps around through the tunnel; Y is bounded by the wall border.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   move_tick    one-cycle step request (captured one-deep if busy)
//   req_dir      requested direction, one-hot {L,D,U,R}; non-one-hot = none
//   valid_moves  legal directions for the current pos (detector output)
//   pos_x/pos_y  registered position (also drives the detector)
//   cur_dir      heading, one-hot, 0 = stopped
//   step_done    one-cycle pulse after each MOVE
//   blocked      high while stopped against a wall
//
// Optional build macro: PACMAN_TURN_BUFFER_EN -- remembers a one-hot request
// that could not be taken yet and retries it at each later tile centre.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pacman_motion_ctrl
    import pacman_pkg::*;
#(
    parameter int          TILE_PX  = TILE_PX_DEF,
    parameter int          STEP_PX  = 2,
    parameter int          MAP_COLS = MAP_COLS_DEF,
    parameter int          MAP_LAT  = 2,
    parameter logic [10:0] START_X  = 11'd624,
    parameter logic [9:0]  START_Y  = 10'd368
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_tick,
    input  logic [3:0]  req_dir,
    input  logic [3:0]  valid_moves,
    output logic [10:0] pos_x,
    output logic [9:0]  pos_y,
    output logic [3:0]  cur_dir,
    output logic        step_done,
    output logic        blocked
);

    localparam int               TILE_BITS   = $clog2(TILE_PX);
    localparam int               CNT_W       = (MAP_LAT < 2) ? 1 : $clog2(MAP_LAT + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(MAP_LAT);
    localparam logic [11:0]      X_SPAN      = 12'(MAP_COLS * TILE_PX);
    localparam logic [11:0]      STEP_X12    = 12'(STEP_PX);
    localparam logic [10:0]      STEP_X      = 11'(STEP_PX);
    localparam logic [10:0]      X_LEFT_WRAP = 11'(MAP_COLS * TILE_PX - STEP_PX);
    localparam logic [9:0]       STEP_Y      = 10'(STEP_PX);

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             pending_q,   pending_d;
    logic [10:0]      pos_x_q,     pos_x_d;
    logic [9:0]       pos_y_q,     pos_y_d;
    logic [3:0]       dir_q,       dir_d;
    logic             step_done_q, step_done_d;
    logic             blocked_q,   blocked_d;

    logic        aligned;
    logic [3:0]  turn_req;
    logic [3:0]  arb_next_dir;
    logic        arb_stop;
    logic [11:0] x_plus;

    assign aligned = (pos_x_q[TILE_BITS-1:0] == '0) && (pos_y_q[TILE_BITS-1:0] == '0);
    // One bit wider than pos_x so the right-edge compare cannot overflow.
    assign x_plus  = {1'b0, pos_x_q} + STEP_X12;

`ifdef PACMAN_TURN_BUFFER_EN
    logic [3:0] turn_buf_q, turn_buf_d;
    logic       req_onehot;

    assign req_onehot = dir_is_onehot(req_dir);
    // A live one-hot request always wins; otherwise retry the remembered one.
    assign turn_req   = req_onehot ? req_dir : turn_buf_q;

    always_comb begin
        turn_buf_d = turn_buf_q;
        if (state_q == ST_MOVE) begin
            if (req_onehot) begin
                // Taken (turn, reversal or same heading) empties the buffer,
                // otherwise the new request overwrites it.
                turn_buf_d = (arb_next_dir == req_dir) ? DIR_NONE : req_dir;
            end else if (aligned && (turn_buf_q != DIR_NONE) && (arb_next_dir == turn_buf_q)) begin
                turn_buf_d = DIR_NONE;
            end
        end else if (req_onehot) begin
            turn_buf_d = req_dir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn_buf_q <= DIR_NONE;
        end else begin
            turn_buf_q <= turn_buf_d;
        end
    end
`else
    // The arbiter rejects non-one-hot requests itself.
    assign turn_req = req_dir;
`endif

    pacman_dir_arbiter u_arbiter (
        .cur_dir_i     (dir_q),
        .req_dir_i     (req_dir),
        .turn_req_i    (turn_req),
        .valid_moves_i (valid_moves),
        .aligned_i     (aligned),
        .next_dir_o    (arb_next_dir),
        .stop_o        (arb_stop)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        dir_d       = dir_q;
        step_done_d = 1'b0;
        blocked_d   = blocked_q;

        case (state_q)
            ST_SETTLE: begin
                // valid_moves is still catching up with the last pos change.
                if (move_tick) begin
                    pending_d = 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_READY: begin
                if (move_tick || pending_q) begin
                    state_d   = ST_MOVE;
                    pending_d = 1'b0;
                end
            end

            ST_MOVE: begin
                if (move_tick) begin
                    pending_d = 1'b1;
                end
                state_d     = ST_SETTLE;
                cnt_d       = SETTLE_LOAD;
                step_done_d = 1'b1;
                dir_d       = arb_next_dir;
                if (arb_stop) begin
                    blocked_d = 1'b1;
                end else if (arb_next_dir != DIR_NONE) begin
                    blocked_d = 1'b0;
                    case (arb_next_dir)
                        DIR_RIGHT: pos_x_d = (x_plus >= X_SPAN) ? 11'd0 : x_plus[10:0];
                        DIR_LEFT:  pos_x_d = (pos_x_q == 11'd0) ? X_LEFT_WRAP : pos_x_q - STEP_X;
                        DIR_DOWN:  pos_y_d = pos_y_q + STEP_Y;
                        DIR_UP:    pos_y_d = pos_y_q - STEP_Y;
                        default:   pos_x_d = pos_x_q;
                    endcase
                end
            end

            default: begin
                state_d = ST_SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SETTLE;
            cnt_q       <= SETTLE_LOAD;
            pending_q   <= 1'b0;
            pos_x_q     <= START_X;
            pos_y_q     <= START_Y;
            dir_q       <= DIR_NONE;
            step_done_q <= 1'b0;
            blocked_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_q       <= dir_d;
            step_done_q <= step_done_d;
            blocked_q   <= blocked_d;
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign cur_dir   = dir_q;
    assign step_done = step_done_q;
    assign blocked   = blocked_q;

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
`timescale 1ns/1ps

module tb_pacman_motion_ctrl;

    localparam int TILE = 16;
    localparam int STEP = 2;
    localparam int SPAN = 80 * TILE;

    localparam logic [3:0] R = 4'b0001;
    localparam logic [3:0] U = 4'b0010;
    localparam logic [3:0] D = 4'b0100;
    localparam logic [3:0] L = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        move_tick = 1'b0;
    logic [3:0]  req_dir = 4'b0;
    logic [3:0]  valid_moves = 4'b0;
    logic [10:0] pos_x;
    logic [9:0]  pos_y;
    logic [3:0]  cur_dir;
    logic        step_done;
    logic        blocked;

    int checks = 0;
    int failures = 0;

    // Reference state, updated once per step from the movement rules.
    int         m_x, m_y;
    logic [3:0] m_dir, m_buf;
    logic       m_blk;

    pacman_motion_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .move_tick   (move_tick),
        .req_dir     (req_dir),
        .valid_moves (valid_moves),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .cur_dir     (cur_dir),
        .step_done   (step_done),
        .blocked     (blocked)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit onehot(input logic [3:0] d);
        return $countones(d) == 1;
    endfunction

    function automatic logic [3:0] opp(input logic [3:0] d);
        if (d == R) return L;
        if (d == L) return R;
        if (d == U) return D;
        if (d == D) return U;
        return 4'b0;
    endfunction

    task automatic model_reset();
        m_x = 624; m_y = 368; m_dir = 4'b0; m_blk = 1'b0; m_buf = 4'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [3:0] v);
        bit         al;
        bit         stop;
        bit         used;
        logic [3:0] nd;
        logic [3:0] eff;
        al   = (m_x % TILE == 0) && (m_y % TILE == 0);
        nd   = m_dir;
        stop = 0;
        used = 0;
        if (onehot(r) && r == opp(m_dir)) begin
            nd = r; used = 1;
        end else if (al) begin
            eff = onehot(r) ? r : 4'b0;
`ifdef PACMAN_TURN_BUFFER_EN
            if (!onehot(r)) eff = m_buf;
`endif
            if (eff != 0 && (eff & v) != 0) begin
                nd = eff; used = 1;
            end else if ((m_dir & v) != 0) begin
                nd = m_dir;
            end else begin
                nd = 4'b0; stop = 1;
            end
        end
        m_dir = nd;
        if (stop) begin
            m_blk = 1'b1;
        end else if (nd != 0) begin
            m_blk = 1'b0;
            if (nd == R)      m_x = (m_x + STEP >= SPAN) ? 0 : m_x + STEP;
            else if (nd == L) m_x = (m_x == 0) ? SPAN - STEP : m_x - STEP;
            else if (nd == D) m_y = m_y + STEP;
            else              m_y = m_y - STEP;
        end
        // The request stays applied after the step, so a one-hot one is remembered.
        if (onehot(r)) m_buf = r;
        else if (used) m_buf = 4'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_x"}, 32'(pos_x), 32'(m_x));
        chk({tag, "_y"}, 32'(pos_y), 32'(m_y));
        chk({tag, "_dir"}, 32'(cur_dir), 32'(m_dir));
        chk({tag, "_blk"}, 32'(blocked), 32'(m_blk));
        $display("step %s pos=(%0d,%0d) dir=%b blocked=%0b", tag, pos_x, pos_y, cur_dir, blocked);
    endtask

    task automatic wait_step(input string tag);
        int n = 0;
        while (step_done !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_step_done"}, 32'(step_done), 32'd1);
    endtask

    task automatic do_step(input logic [3:0] r, input logic [3:0] v, input string tag);
        req_dir = r;
        valid_moves = v;
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        wait_step(tag);
        model_step(r, v);
        check_state(tag);
    endtask

    initial begin
        int         n;
        logic [3:0] r;
        logic [3:0] v;
        logic [3:0] picks [4];
        picks[0] = 4'b0000; picks[1] = L; picks[2] = 4'b0011; picks[3] = 4'b1111;

        // ---- reset values ----
        model_reset();
        repeat (3) cyc();
        chk("rst_x", 32'(pos_x), 32'd624);
        chk("rst_y", 32'(pos_y), 32'd368);
        chk("rst_dir", 32'(cur_dir), 32'd0);
        chk("rst_step_done", 32'(step_done), 32'd0);
        chk("rst_blocked", 32'(blocked), 32'd0);

        // ---- 1: tick at reset release: 2 settle cycles, READY, MOVE ----
        rst_n = 1'b1; req_dir = 4'b0; valid_moves = 4'b1001; move_tick = 1'b1;
        cyc(); move_tick = 1'b0;
        chk("lat_c1", 32'(step_done), 32'd0);
        cyc(); chk("lat_c2", 32'(step_done), 32'd0);
        cyc(); chk("lat_c3", 32'(step_done), 32'd0);
        cyc(); chk("lat_c4", 32'(step_done), 32'd1);
        model_step(4'b0, 4'b1001);
        check_state("t1_blocked");
        cyc(); chk("pulse_width", 32'(step_done), 32'd0);

        // ---- 2: eight steps right from 624 to 640 ----
        for (int i = 0; i < 8; i++) do_step(R, 4'b0001, "t2_right");
        chk("t2_end_x", 32'(pos_x), 32'd640);

        // ---- 3: mid-tile ignores turn, reversal is immediate ----
        do_step(R, 4'b0001, "t3_aligned");
        do_step(U, 4'b0010, "t3_offgrid_up");
        chk("t3_still_right", 32'(cur_dir), 32'(R));
        do_step(L, 4'b0010, "t3_reverse");
        chk("t3_rev_x", 32'(pos_x), 32'd642);

        // ---- 4: run left through x=0 to the far side, then reverse right ----
        n = 0;
        while (m_x != SPAN - STEP && n < 400) begin
            r = picks[$urandom_range(0, 3)];
            v = 4'($urandom_range(0, 15)) | L;
            do_step(r, v, "t4_left");
            n++;
        end
        chk("t4_left_wrap_x", 32'(pos_x), 32'd1278);
        do_step(R, 4'($urandom_range(0, 15)), "t4_right_wrap");
        chk("t4_right_wrap_x", 32'(pos_x), 32'd0);

        // ---- 5: two back-to-back ticks while settling -> one step ----
        move_tick = 1'b1; cyc(); cyc(); move_tick = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (step_done === 1'b1) n++;
            cyc();
        end
        chk("t5_one_step", 32'(n), 32'd1);
        model_step(req_dir, valid_moves);
        check_state("t5_after");

        // ---- async reset with a pending tick: tick discarded ----
        do_step(R, 4'b0001, "pre_reset");
        move_tick = 1'b1; cyc(); move_tick = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_rst_x", 32'(pos_x), 32'd624);
        cyc(); rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (step_done === 1'b1) n++;
            cyc();
        end
        chk("rst_drops_pending", 32'(n), 32'd0);
        model_reset();
        check_state("after_reset");

        // ---- 6: one-cycle Up request at x=630, tile centre at 640 ----
        for (int i = 0; i < 3; i++) do_step(R, 4'b0001, "t6_right");
        req_dir = U; cyc(); req_dir = 4'b0;
        if (onehot(U)) m_buf = U;
        for (int i = 0; i < 5; i++) do_step(4'b0, 4'b0001, "t6_coast");
        do_step(4'b0, 4'b0011, "t6_centre");
`ifdef PACMAN_TURN_BUFFER_EN
        chk("t6_dir", 32'(cur_dir), 32'(U));
`else
        chk("t6_dir", 32'(cur_dir), 32'(R));
`endif

        // ---- random walk against the reference ----
        for (int i = 0; i < 150; i++) begin
            r = 4'($urandom_range(0, 15));
            v = 4'($urandom_range(0, 15));
            if (m_y == 0)   v = v & ~U;
            if (m_y >= 992) v = v & ~D;
            repeat ($urandom_range(0, 3)) cyc();
            do_step(r, v, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
